mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
- Load/store unit at the memory-access end of the EX->MEM control pipeline register; it consumes the pipelined M-stage control bundle (MemWriteM, ResultSrcM, funct3m) plus address and store data.
- Runs a handshake with a variable-latency data memory.
- Generates byte enables and sign/zero-extended load data.
- Raises StallM to freeze IF..M while an access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles in REQ waiting for mem_ready before a bus error.
- CNT_W, 8: width of the wait counter (must hold TIMEOUT_CYCLES).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- MemWriteM  in  1  store in M stage
- ResultSrcM  in  2  2'b01 = load result in M stage
- funct3m  in  3  access size/sign
- ALUResultM  in  32  byte address
- WriteDataM  in  32  store data (rs2)
- mem_req  out  1  request valid, held until mem_ready
- mem_we  out  1  1 = write
- mem_addr  out  32  word-aligned address {ALUResultM[31:2],2'b00}
- mem_wdata  out  32  lane-aligned store data
- mem_be  out  4  byte enables
- mem_ready  in  1  memory accepts/completes in this cycle
- mem_rdata  in  32  read word, valid when mem_ready
- ReadDataM  out  32  extended load data
- StallM  out  1  hold pipeline stages IF..M
- MisalignM  out  1  misaligned or illegal access, 1-cycle pulse
- BusErrM  out  1  timeout, 1-cycle pulse

Behaviour:
- Access decode:
  - store = MemWriteM.
  - load = (ResultSrcM==2'b01) & ~MemWriteM; store takes priority if both are set.
  - acc = store | load.
- funct3 encodings:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
- FSM states IDLE, REQ, DONE; state, counter and captured data are registered.
- IDLE:
  - If acc and the access is legal and aligned: StallM=1, next state REQ, counter cleared.
  - If acc and the access is illegal or misaligned: MisalignM=1, StallM=0, no request, stay IDLE.
  - If no acc: StallM=0.
- REQ:
  - Outputs: mem_req=1, mem_we=store, mem_addr/mem_be/mem_wdata driven from current inputs, StallM=1.
  - On mem_ready: capture mem_rdata (loads only), go to DONE.
  - Otherwise increment the counter. When counter==TIMEOUT_CYCLES-1 without mem_ready: go to DONE with the error flag set, captured data = 0.
- DONE:
  - StallM=0, and the pipeline advances at the end of this cycle.
  - BusErrM=1 if the error flag is set.
  - ReadDataM is driven from the captured word.
  - Next state is always IDLE, so a back-to-back access gets a fresh handshake.
- Latency: zero-wait memory gives 2 stall cycles per access; each extra wait cycle adds 1.
- Byte enables, with o = addr[1:0]:
  - SB: 4'b0001<<o.
  - SH: 4'b0011<<o.
  - SW: 4'b1111.
- Store data alignment:
  - SB: mem_wdata = {4{WriteDataM[7:0]}}.
  - SH: mem_wdata = {2{WriteDataM[15:0]}}.
  - SW: mem_wdata = WriteDataM.
- Load extraction: take captured >> (8*o), then extend:
  - LB: sign-extend [7:0].
  - LBU: zero-extend [7:0].
  - LH: sign-extend [15:0].
  - LHU: zero-extend [15:0].
  - LW: full word.
- Outside DONE, ReadDataM=0.
- Outside REQ: mem_req=0, mem_we=0, mem_be=0.
- Reset, including mid-REQ:
  - Asynchronously: state=IDLE, counter=0, captured data=0, error flag=0.
  - mem_req drops in the same cycle; all outputs are 0.
  - An aborted store is not retried.
- mem_ready outside REQ is ignored.

Test Plan:
- LW, addr 0x100, mem_ready in the first REQ cycle, rdata 0xDEADBEEF -> StallM high 2 cycles; mem_addr=0x100, mem_be=0; ReadDataM=0xDEADBEEF in DONE.
- LB at 0x103, rdata 0x80112233 -> ReadDataM=0xFFFFFF80. LBU at the same address -> 0x00000080. LH at 0x102 -> 0xFFFF8011.
- SH at 0x0FE, WriteDataM 0x1234ABCD, mem_ready after 3 wait cycles -> mem_req held 4 cycles, mem_we=1, mem_be=4'b1100, mem_wdata=0xABCDABCD, stall 5 cycles.
- LW at 0x101, then funct3 011 load -> MisalignM pulse each time, mem_req never asserted, StallM=0.
- mem_ready never asserted, TIMEOUT_CYCLES=4 -> 4 REQ cycles, then DONE with BusErrM=1 and ReadDataM=0, then IDLE.
- reset asserted during the 2nd REQ cycle of a store -> mem_req/StallM fall immediately, state is IDLE after release, and no access is issued until a new acc.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// M-stage load/store unit: memory handshake, byte lanes, load extension.
// Holds IF..M via StallM while an access is outstanding.
module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [2:0]  funct3m,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_data;
  logic             r_err;

  logic        w_store;
  logic        w_load;
  logic        w_acc;
  logic        w_legal;
  logic        w_misal;
  logic        w_ok;
  logic        w_tmo;
  logic [1:0]  w_off;
  logic [31:0] w_sh;

  assign w_store = MemWriteM;
  assign w_load  = (ResultSrcM == 2'b01) & ~MemWriteM;
  assign w_acc   = w_store | w_load;
  assign w_off   = ALUResultM[1:0];
  assign w_tmo   = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_sh    = r_data >> {w_off, 3'b000};

  always_comb begin
    w_legal = 1'b0;
    case (funct3m)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = w_load;
      default:                w_legal = 1'b0;
    endcase
  end

  assign w_misal = ((funct3m[1:0] == 2'b01) & w_off[0])
                 | ((funct3m[1:0] == 2'b10) & (w_off != 2'b00));
  assign w_ok    = w_acc & w_legal & ~w_misal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_ok) w_next = S_REQ;
      S_REQ:   if (mem_ready | w_tmo) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Timeout ends the access with zeroed data and the error flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_data <= '0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ok) begin
            r_cnt  <= '0;
            r_data <= '0;
            r_err  <= 1'b0;
          end
        end
        S_REQ: begin
          if (mem_ready) begin
            r_data <= w_load ? mem_rdata : 32'd0;
            r_err  <= 1'b0;
          end else if (w_tmo) begin
            r_data <= '0;
            r_err  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    ReadDataM = '0;
    StallM    = 1'b0;
    MisalignM = 1'b0;
    BusErrM   = 1'b0;
    if (!reset) begin
      unique case (r_state)
        S_IDLE: begin
          StallM    = w_ok;
          MisalignM = w_acc & ~w_ok;
        end
        S_REQ: begin
          mem_req  = 1'b1;
          mem_we   = w_store;
          mem_addr = {ALUResultM[31:2], 2'b00};
          StallM   = 1'b1;
          unique case (funct3m[1:0])
            2'b00: begin
              mem_wdata = {4{WriteDataM[7:0]}};
              mem_be    = 4'b0001 << w_off;
            end
            2'b01: begin
              mem_wdata = {2{WriteDataM[15:0]}};
              mem_be    = 4'b0011 << w_off;
            end
            default: begin
              mem_wdata = WriteDataM;
              mem_be    = 4'b1111;
            end
          endcase
          if (!w_store) mem_be = 4'b0000;
        end
        S_DONE: begin
          BusErrM = r_err;
          case (funct3m)
            3'b000:  ReadDataM = {{24{w_sh[7]}}, w_sh[7:0]};
            3'b001:  ReadDataM = {{16{w_sh[15]}}, w_sh[15:0]};
            3'b100:  ReadDataM = {24'd0, w_sh[7:0]};
            3'b101:  ReadDataM = {16'd0, w_sh[15:0]};
            default: ReadDataM = w_sh;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: transaction-level model builds a per-cycle
// expectation queue; one negedge process compares the DUT against it.
module tb_mem_stage_lsu;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  funct3m;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        MisalignM;
  logic        BusErrM;

  int tests = 0;
  int fails = 0;

  mem_stage_lsu #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .funct3m(funct3m), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .ReadDataM(ReadDataM),
    .StallM(StallM), .MisalignM(MisalignM),
    .BusErrM(BusErrM)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rd;
    logic        stall;
    logic        mis;
    logic        berr;
  } exp_t;

  exp_t expq[$];

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", n, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      chk("mem_req", 32'(mem_req), 32'(e.req));
      chk("mem_we", 32'(mem_we), 32'(e.we));
      chk("mem_be", 32'(mem_be), 32'(e.be));
      chk("ReadDataM", ReadDataM, e.rd);
      chk("StallM", 32'(StallM), 32'(e.stall));
      chk("MisalignM", 32'(MisalignM), 32'(e.mis));
      chk("BusErrM", 32'(BusErrM), 32'(e.berr));
      if (e.req) begin
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_wdata", mem_wdata, e.wdata);
      end
    end
  end

  function automatic exp_t zero_e();
    exp_t e;
    e.req = 0; e.we = 0; e.addr = 0; e.wdata = 0; e.be = 0;
    e.rd = 0; e.stall = 0; e.mis = 0; e.berr = 0;
    return e;
  endfunction

  function automatic int nbytes(input logic [2:0] f);
    return 1 << f[1:0];
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f,
                                      input logic [1:0] o);
    int nb = nbytes(f);
    if (nb >= 4) return 4'hF;
    return 4'(((1 << nb) - 1) << o);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f,
                                          input logic [31:0] d);
    if (nbytes(f) == 1) return 32'(d[7:0]) * 32'h01010101;
    if (nbytes(f) == 2) return 32'(d[15:0]) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_ext(input logic [2:0] f,
                                        input logic [1:0] o,
                                        input logic [31:0] w);
    logic [31:0] s = w >> (8 * o);
    logic [31:0] b = s % 32'd256;
    logic [31:0] h = s % 32'd65536;
    case (f)
      3'b000:  return (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'b101:  return h;
      default: return s;
    endcase
  endfunction

  function automatic bit m_ok(input bit st, input logic [2:0] f,
                              input logic [31:0] a);
    bit legal = st ? (f <= 2) : (f <= 2 || f == 4 || f == 5);
    return legal && ((a % nbytes(f)) == 0);
  endfunction

  task automatic step(input exp_t e, input logic rdy);
    mem_ready = rdy;
    expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    MemWriteM  = 1'b0;
    ResultSrcM = ($urandom % 2) ? 2'b00 : 2'(2 + $urandom % 2);
    mem_rdata  = $urandom;
    step(zero_e(), 1'($urandom % 2));
  endtask

  // w = wait cycles before mem_ready; w >= T never answers.
  task automatic access(input bit st, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rw, input int w);
    exp_t e;
    int   nreq;
    MemWriteM  = st;
    ResultSrcM = st ? 2'($urandom % 4) : 2'b01;
    funct3m    = f;
    ALUResultM = a;
    WriteDataM = wd;
    mem_rdata  = $urandom;
    e = zero_e();
    if (!m_ok(st, f, a)) begin
      e.mis = 1;
      step(e, 1'($urandom % 2));
      return;
    end
    nreq = (w < T) ? w + 1 : T;
    e.stall = 1;
    step(e, 1'($urandom % 2));
    for (int i = 0; i < nreq; i++) begin
      logic rdy;
      e = zero_e();
      e.req   = 1;
      e.we    = st;
      e.addr  = a - (a % 4);
      e.be    = st ? m_be(f, a[1:0]) : 4'h0;
      e.wdata = m_wdata(f, wd);
      e.stall = 1;
      rdy = (w < T) && (i == w);
      mem_rdata = rdy ? rw : $urandom;
      step(e, rdy);
    end
    e = zero_e();
    e.berr = (w >= T);
    e.rd   = (!st && w < T) ? m_ext(f, a[1:0], rw) : 32'd0;
    mem_rdata = $urandom;
    step(e, 1'($urandom % 2));
  endtask

  initial begin
    exp_t e;
    reset      = 1'b1;
    MemWriteM  = 1'b0;
    ResultSrcM = 2'b00;
    funct3m    = 3'b000;
    ALUResultM = 32'd0;
    WriteDataM = 32'd0;
    mem_ready  = 1'b0;
    mem_rdata  = 32'd0;
    @(posedge clk);
    #1;
    step(zero_e(), 1'b0);
    MemWriteM = 1'b1;
    funct3m   = 3'b010;
    step(zero_e(), 1'b1);
    reset     = 1'b0;
    MemWriteM = 1'b0;
    idle_cycle();

    chk("pin_lb", m_ext(3'b000, 2'd3, 32'h80112233), 32'hFFFFFF80);
    chk("pin_lbu", m_ext(3'b100, 2'd3, 32'h80112233), 32'h00000080);
    chk("pin_lh", m_ext(3'b001, 2'd2, 32'h80112233), 32'hFFFF8011);
    chk("pin_sh_be", 32'(m_be(3'b001, 2'd2)), 32'hC);
    chk("pin_sh_wd", m_wdata(3'b001, 32'h1234ABCD), 32'hABCDABCD);

    access(0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    access(0, 3'b000, 32'h103, 32'h0, 32'h80112233, 0);
    access(0, 3'b100, 32'h103, 32'h0, 32'h80112233, 1);
    access(0, 3'b001, 32'h102, 32'h0, 32'h80112233, 2);
    access(1, 3'b001, 32'h0FE, 32'h1234ABCD, 32'h0, 3);
    access(0, 3'b010, 32'h101, 32'h0, 32'h0, 0);
    access(0, 3'b011, 32'h100, 32'h0, 32'h0, 0);
    idle_cycle();
    access(0, 3'b010, 32'h200, 32'h0, 32'h55AA55AA, T + 5);
    access(1, 3'b000, 32'h201, 32'hA5, 32'h0, T);

    MemWriteM  = 1'b1;
    ResultSrcM = 2'b00;
    funct3m    = 3'b010;
    ALUResultM = 32'h300;
    WriteDataM = 32'hCAFEF00D;
    e = zero_e();
    e.stall = 1;
    step(e, 1'b0);
    e.req = 1; e.we = 1; e.addr = 32'h300;
    e.wdata = 32'hCAFEF00D; e.be = 4'hF;
    step(e, 1'b0);
    reset = 1'b1;
    step(zero_e(), 1'b0);
    reset     = 1'b0;
    MemWriteM = 1'b0;
    step(zero_e(), 1'b1);
    idle_cycle();
    access(0, 3'b101, 32'h302, 32'h0, 32'h9ABC1234, 0);

    for (int n = 0; n < 200; n++) begin
      bit          st = 1'($urandom % 2);
      logic [2:0]  f;
      logic [31:0] a = 32'h1000 + 32'($urandom % 64);
      int          w = $urandom % (T + 3);
      if ($urandom % 5 == 0) f = 3'($urandom % 8);
      else f = st ? 3'($urandom % 3) : 3'($urandom % 2 ? $urandom % 3 : 4 + $urandom % 2);
      if ($urandom % 2) a = a - (a % 32'(nbytes(f)));
      access(st, f, a, $urandom, $urandom, w);
      if ($urandom % 3 == 0) idle_cycle();
    end

    idle_cycle();
    @(negedge clk);
    #1;
    tests++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d expected 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
